// File: rtl/pmcc_fetch_unit.sv
// PMCC instruction fetch unit: owns the program counter, drives code RAM port B and
// hands 32-bit words to the decoder over a valid/ready handshake.
module pmcc_fetch_unit #(
  parameter int DEPTH    = 256,
  parameter int RESET_PC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] start_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        busy,
  output logic        err_misaligned,
  output logic [31:0] instr_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] RESET_ADDR = AW'(RESET_PC);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] redir_addr;
  logic [AW-1:0] addr_next;
  logic          start_aligned;
  logic          redir_aligned;
  logic          in_run;
  logic          transfer;
  logic          err_q;
  logic [31:0]   count_q;
  logic          unused_addr_bits;

  assign start_addr       = start_pc[AW-1:0];
  assign redir_addr       = redirect_pc[AW-1:0];
  assign start_aligned    = (start_pc[1:0] == 2'b00);
  assign redir_aligned    = (redirect_pc[1:0] == 2'b00);
  assign pc_inc           = pc_q + AW'(4);
  assign in_run           = (state_q == RUN);
  assign transfer         = in_run & instr_ready;
  assign unused_addr_bits = ^{start_pc[31:AW], redirect_pc[31:AW]};

  // The RAM registers its address, so we present the address of the word needed
  // next cycle; this is what makes stalls, redirects and restarts bubble-free.
  always_comb begin
    addr_next = pc_q;
    if (!in_run) begin
      if (start) addr_next = start_addr;
    end else if (halt) begin
      addr_next = pc_q;
    end else if (redirect) begin
      addr_next = redir_addr;
    end else if (instr_ready) begin
      addr_next = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_ADDR;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (start_aligned) begin
              pc_q    <= start_addr;
              count_q <= '0;
              err_q   <= 1'b0;
              state_q <= RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (transfer) count_q <= count_q + 32'd1;
          // halt beats redirect beats a plain advance
          if (halt) begin
            state_q <= IDLE;
          end else if (redirect) begin
            if (redir_aligned) begin
              pc_q <= redir_addr;
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end else if (instr_ready) begin
            pc_q <= pc_inc;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr       = {{(32-AW){1'b0}}, addr_next};
  assign instr_pc       = {{(32-AW){1'b0}}, pc_q};
  assign instr_valid    = in_run;
  assign busy           = in_run;
  assign instr          = in_run ? mem_rdata : 32'h0;
  assign err_misaligned = err_q;
  assign instr_count    = count_q;

endmodule

// File: tb/tb_pmcc_fetch_unit.sv
// Directed bench for pmcc_fetch_unit with a behavioural registered code RAM on port B.
module tb_pmcc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_pc = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        busy;
  logic        err_misaligned;
  logic [31:0] instr_count;

  logic [31:0] mem [64];
  int checkCount = 0;
  int errorCount = 0;

  pmcc_fetch_unit #(.DEPTH(256), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy),
    .err_misaligned(err_misaligned), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr[7:2]];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] spc, input logic r,
                               input logic [31:0] rpc, input logic h, input logic rdy);
    start = s; start_pc = spc; redirect = r; redirect_pc = rpc; halt = h; instr_ready = rdy;
    #1;
  endtask

  task automatic checkWord(input string tag, input logic [31:0] pc, input logic [31:0] word,
                           input logic [31:0] cnt);
    checkOutput({tag, ".valid"}, {31'b0, instr_valid}, 32'd1);
    checkOutput({tag, ".pc"}, instr_pc, pc);
    checkOutput({tag, ".instr"}, instr, word);
    checkOutput({tag, ".count"}, instr_count, cnt);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".valid"}, {31'b0, instr_valid}, 32'd0);
    checkOutput({tag, ".busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, ".instr"}, instr, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 | i;

    #2;
    checkIdle("reset");
    checkOutput("reset.count", instr_count, 32'd0);
    checkOutput("reset.err", {31'b0, err_misaligned}, 32'd0);
    checkOutput("reset.mem_addr", mem_addr, 32'd0);
    checkOutput("reset.instr_pc", instr_pc, 32'd0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();

    // start at 0 with ready, then stall on the word at 0x04
    applyStimulus(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("start.mem_addr", mem_addr, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkWord("run0", 32'h00, 32'hC0DE_0000, 32'd0);
    checkOutput("run0.busy", {31'b0, busy}, 32'd1);
    checkOutput("run0.mem_addr", mem_addr, 32'h04);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkWord("stall", 32'h04, 32'hC0DE_0001, 32'd1);
      checkOutput("stall.mem_addr", mem_addr, 32'h04);
      nextCycle();
    end
    mem[1] = 32'h1234_5678;
    nextCycle();
    checkWord("stallwr", 32'h04, 32'h1234_5678, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    nextCycle();
    checkWord("run8", 32'h08, 32'hC0DE_0002, 32'd2);

    // redirect with ready, then redirect while stalled
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 1'b1);
    checkOutput("redir.mem_addr", mem_addr, 32'h40);
    nextCycle();
    checkWord("redir40", 32'h40, 32'hC0DE_0010, 32'd3);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0);
    nextCycle();
    checkWord("redir80", 32'h80, 32'hC0DE_0020, 32'd3);

    // wrap past the top of the code RAM
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hF8, 1'b0, 1'b1);
    nextCycle();
    checkWord("runF8", 32'hF8, 32'hC0DE_003E, 32'd4);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    nextCycle();
    checkWord("runFC", 32'hFC, 32'hC0DE_003F, 32'd5);
    checkOutput("wrap.mem_addr", mem_addr, 32'h0);
    nextCycle();
    checkWord("wrap0", 32'h00, 32'hC0DE_0000, 32'd6);

    // halt wins over a simultaneous redirect
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
    checkOutput("halt.mem_addr", mem_addr, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkIdle("halt");
    checkOutput("halt.count", instr_count, 32'd6);

    // misaligned start, recovery, misaligned redirect
    applyStimulus(1'b1, 32'h06, 1'b0, 32'h0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("badstart.err", {31'b0, err_misaligned}, 32'd1);
    checkIdle("badstart");
    applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b1);
    nextCycle();
    checkOutput("restart.err", {31'b0, err_misaligned}, 32'd0);
    checkWord("restart", 32'h10, 32'hC0DE_0004, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h41, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("badredir.err", {31'b0, err_misaligned}, 32'd1);
    checkIdle("badredir");
    checkOutput("badredir.count", instr_count, 32'd1);

    // asynchronous reset in the middle of a run
    applyStimulus(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    nextCycle();
    checkWord("prerst", 32'h24, 32'hC0DE_0009, 32'd1);
    rst_n = 1'b0;
    #1;
    checkIdle("asyncrst");
    checkOutput("asyncrst.count", instr_count, 32'd0);
    checkOutput("asyncrst.mem_addr", mem_addr, 32'h0);
    checkOutput("asyncrst.instr_pc", instr_pc, 32'h0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    checkIdle("postrst");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
